// File: rtl/pipe_pkg.sv
// Shared types for the decode hazard controller: FSM states, register index width, tracker entry.
package pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest;
        logic                 is_load;
    } track_entry_t;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// ID-stage request and pipeline-control response bundle for decode_hazard_ctrl.
interface decode_hazard_ctrl_if;
    import pipe_pkg::*;

    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_src1;
    logic [REG_IDX_W-1:0] id_src2;
    logic [REG_IDX_W-1:0] id_dest;
    logic                 id_writes;
    logic                 id_is_load;
    logic                 ex_mispredict;
    logic                 stall_if;
    logic                 stall_id;
    logic                 bubble_ex;
    logic                 flush_if;
    logic                 flush_id;
    logic [1:0]           ctrl_state;
    logic [15:0]          stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_dest, id_writes, id_is_load, ex_mispredict,
        input  stall_if, stall_id, bubble_ex, flush_if, flush_id, ctrl_state, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_dest, id_writes, id_is_load, ex_mispredict,
        output stall_if, stall_id, bubble_ex, flush_if, flush_id, ctrl_state, stall_cnt
    );

endinterface

// File: rtl/hazard_tracker.sv
// In-flight destination tracker (EX, MEM, WB...) with source comparators producing the hazard flag.
// DECODE_HAZARD_FORWARD_EN: only a load sitting in EX can cause a hazard (load-use).
module hazard_tracker
    import pipe_pkg::*;
#(
    parameter int TRACK_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  track_entry_t         i_entry,
    input  logic                 i_id_valid,
    input  logic [REG_IDX_W-1:0] i_src1,
    input  logic [REG_IDX_W-1:0] i_src2,
    output logic                 o_hazard
);

    track_entry_t r_entries [TRACK_DEPTH];
    logic         w_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TRACK_DEPTH; k++) begin
                r_entries[k] <= '0;
            end
        end else begin
            r_entries[0] <= i_entry;
            for (int k = 1; k < TRACK_DEPTH; k++) begin
                r_entries[k] <= r_entries[k-1];
            end
        end
    end

    always_comb begin
        w_match = 1'b0;
`ifdef DECODE_HAZARD_FORWARD_EN
        if (r_entries[0].valid && r_entries[0].is_load &&
            ((r_entries[0].dest == i_src1) || (r_entries[0].dest == i_src2))) begin
            w_match = 1'b1;
        end
`else
        for (int k = 0; k < TRACK_DEPTH; k++) begin
            if (r_entries[k].valid &&
                ((r_entries[k].dest == i_src1) || (r_entries[k].dest == i_src2))) begin
                w_match = 1'b1;
            end
        end
`endif
    end

    assign o_hazard = i_id_valid && w_match;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode hazard controller: RUN/STALL/FLUSH FSM, flush timer and saturating stall counter.
// Optional DECODE_HAZARD_FORWARD_EN narrows hazards to load-use (handled in hazard_tracker).
module decode_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int TRACK_DEPTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_hazard_ctrl_if.slave  hz_bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    ctrl_state_e  r_state;
    ctrl_state_e  w_next_state;
    logic [2:0]   r_flush_cnt;
    logic [2:0]   w_next_flush_cnt;
    logic [15:0]  r_stall_cnt;
    logic         w_hazard;
    logic         w_active;
    track_entry_t w_new_entry;

    assign w_active = (r_state == RUN) || (r_state == STALL);

    // Only an instruction that actually issues into EX this cycle is recorded as in flight.
    assign w_new_entry.valid   = (r_state == RUN) && !w_hazard && hz_bus.id_valid && hz_bus.id_writes;
    assign w_new_entry.dest    = hz_bus.id_dest;
    assign w_new_entry.is_load = hz_bus.id_is_load;

    hazard_tracker #(
        .TRACK_DEPTH (TRACK_DEPTH)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_entry    (w_new_entry),
        .i_id_valid (hz_bus.id_valid),
        .i_src1     (hz_bus.id_src1),
        .i_src2     (hz_bus.id_src2),
        .o_hazard   (w_hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_flush_cnt;
        end
    end

    // A mispredict always wins; inside FLUSH it restarts the full flush window.
    always_comb begin
        w_next_state     = r_state;
        w_next_flush_cnt = r_flush_cnt;
        case (r_state)
            RUN, STALL: begin
                if (hz_bus.ex_mispredict) begin
                    w_next_state     = FLUSH;
                    w_next_flush_cnt = FLUSH_LOAD;
                end else if (w_hazard) begin
                    w_next_state = STALL;
                end else begin
                    w_next_state = RUN;
                end
            end
            FLUSH: begin
                if (hz_bus.ex_mispredict) begin
                    w_next_flush_cnt = FLUSH_LOAD;
                end else if (r_flush_cnt <= 3'd1) begin
                    w_next_state     = RUN;
                    w_next_flush_cnt = '0;
                end else begin
                    w_next_flush_cnt = r_flush_cnt - 3'd1;
                end
            end
            default: begin
                w_next_state     = RUN;
                w_next_flush_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == STALL) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign hz_bus.stall_if   = w_active && w_hazard;
    assign hz_bus.stall_id   = w_active && w_hazard;
    assign hz_bus.bubble_ex  = w_active && w_hazard;
    assign hz_bus.flush_if   = (r_state == FLUSH);
    assign hz_bus.flush_id   = (r_state == FLUSH);
    assign hz_bus.ctrl_state = r_state;
    assign hz_bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: directed scenarios plus random traffic vs. a queue model.
// Honors DECODE_HAZARD_FORWARD_EN when compiled together with the RTL.
module tb_decode_hazard_ctrl;
    import pipe_pkg::*;

    localparam int FLUSH_CYCLES = 2;
    localparam int TRACK_DEPTH  = 3;
`ifdef DECODE_HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    decode_hazard_ctrl_if hzBus ();

    decode_hazard_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .TRACK_DEPTH  (TRACK_DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .hz_bus (hzBus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [4:0] src1;
        logic [4:0] src2;
        logic [4:0] dest;
        logic       writes;
        logic       load;
        logic       mis;
    } stim_t;

    typedef struct {
        int dest;
        bit load;
        int age;
    } flightRec_t;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: in-flight producers with their age in stages, plus controller mode.
    flightRec_t inflight[$];
    int mMode      = 0;
    int mFlushLeft = 0;
    int mStallCnt  = 0;

    function automatic stim_t mk(bit v, int s1, int s2, int d, bit w, bit l, bit m);
        stim_t s;
        s.valid  = v;
        s.src1   = 5'(s1);
        s.src2   = 5'(s2);
        s.dest   = 5'(d);
        s.writes = w;
        s.load   = l;
        s.mis    = m;
        return s;
    endfunction

    function automatic bit modelHazard(stim_t s);
        if (!s.valid) return 1'b0;
        foreach (inflight[i]) begin
            if ((inflight[i].dest == int'(s.src1)) || (inflight[i].dest == int'(s.src2))) begin
                if (!FWD) return 1'b1;
                if (inflight[i].age == 0 && inflight[i].load) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic resetModel();
        inflight.delete();
        mMode      = 0;
        mFlushLeft = 0;
        mStallCnt  = 0;
    endtask

    task automatic modelAdvance(stim_t s);
        bit         hz;
        bit         issue;
        flightRec_t rec;
        flightRec_t aged[$];
        hz    = modelHazard(s);
        issue = (mMode == 0) && !hz && s.valid && s.writes;
        if (mMode == 1) mStallCnt = (mStallCnt >= 65535) ? 65535 : mStallCnt + 1;
        if (mMode != 2) begin
            if (s.mis) begin
                mMode      = 2;
                mFlushLeft = FLUSH_CYCLES;
            end else begin
                mMode = hz ? 1 : 0;
            end
        end else if (s.mis) begin
            mFlushLeft = FLUSH_CYCLES;
        end else begin
            mFlushLeft--;
            if (mFlushLeft == 0) mMode = 0;
        end
        foreach (inflight[i]) begin
            if (inflight[i].age + 1 < TRACK_DEPTH) begin
                rec     = inflight[i];
                rec.age = rec.age + 1;
                aged.push_back(rec);
            end
        end
        if (issue) begin
            rec.dest = int'(s.dest);
            rec.load = s.load;
            rec.age  = 0;
            aged.push_back(rec);
        end
        inflight = aged;
    endtask

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(stim_t s);
        hzBus.id_valid      = s.valid;
        hzBus.id_src1       = s.src1;
        hzBus.id_src2       = s.src2;
        hzBus.id_dest       = s.dest;
        hzBus.id_writes     = s.writes;
        hzBus.id_is_load    = s.load;
        hzBus.ex_mispredict = s.mis;
    endtask

    // Entered at posedge+1; checks every output against the model, then crosses one edge.
    task automatic runCycle(stim_t s, string tag);
        bit hz;
        bit active;
        applyStimulus(s);
        #2;
        hz     = modelHazard(s);
        active = (mMode != 2);
        checkOutput({tag, ".state"},     32'(hzBus.ctrl_state), 32'(mMode));
        checkOutput({tag, ".stall_if"},  32'(hzBus.stall_if),   32'(hz && active));
        checkOutput({tag, ".stall_id"},  32'(hzBus.stall_id),   32'(hz && active));
        checkOutput({tag, ".bubble_ex"}, 32'(hzBus.bubble_ex),  32'(hz && active));
        checkOutput({tag, ".flush_if"},  32'(hzBus.flush_if),   32'(!active));
        checkOutput({tag, ".flush_id"},  32'(hzBus.flush_id),   32'(!active));
        checkOutput({tag, ".stall_cnt"}, 32'(hzBus.stall_cnt),  32'(mStallCnt));
        @(posedge clk);
        modelAdvance(s);
        #1;
    endtask

    task automatic checkAllZero(string tag);
        checkOutput({tag, ".state"},     32'(hzBus.ctrl_state), 32'd0);
        checkOutput({tag, ".stall_if"},  32'(hzBus.stall_if),   32'd0);
        checkOutput({tag, ".stall_id"},  32'(hzBus.stall_id),   32'd0);
        checkOutput({tag, ".bubble_ex"}, 32'(hzBus.bubble_ex),  32'd0);
        checkOutput({tag, ".flush_if"},  32'(hzBus.flush_if),   32'd0);
        checkOutput({tag, ".flush_id"},  32'(hzBus.flush_id),   32'd0);
        checkOutput({tag, ".stall_cnt"}, 32'(hzBus.stall_cnt),  32'd0);
    endtask

    initial begin
        stim_t idle;
        stim_t rd;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(mk(1, 0, 0, 0, 1, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        applyStimulus(idle);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        resetModel();

        // Non-load producer r3 in EX, consumer reads r3.
        runCycle(mk(1, 10, 11, 3, 1, 0, 0), "r033.prod");
        rd = mk(1, 3, 12, 20, 0, 0, 0);
        repeat (4) runCycle(rd, "r033.cons");
        checkOutput("r033.cnt",   32'(hzBus.stall_cnt),  FWD ? 32'd0 : 32'd3);
        checkOutput("r033.state", 32'(hzBus.ctrl_state), 32'd0);

        // Load producer r7, consumer via src2.
        runCycle(mk(1, 10, 11, 7, 1, 1, 0), "r034.prod");
        rd = mk(1, 13, 7, 21, 0, 0, 0);
        repeat (4) runCycle(rd, "r034.cons");
        checkOutput("r034.cnt", 32'(hzBus.stall_cnt), FWD ? 32'd1 : 32'd6);

        // Mispredict in RUN; writer to r9 during flush must not be tracked.
        runCycle(mk(0, 0, 0, 0, 0, 0, 1), "r035.mis");
        checkOutput("r035.st1", 32'(hzBus.ctrl_state), 32'd2);
        runCycle(mk(1, 14, 15, 9, 1, 0, 0), "r035.f1");
        checkOutput("r035.st2", 32'(hzBus.ctrl_state), 32'd2);
        runCycle(mk(1, 14, 15, 9, 1, 0, 0), "r035.f2");
        checkOutput("r035.st3", 32'(hzBus.ctrl_state), 32'd0);
        checkOutput("r035.fl3", 32'(hzBus.flush_if),   32'd0);
        runCycle(mk(1, 9, 9, 0, 0, 0, 0), "r035.rd9");

        // Hazard and mispredict together; then a second mispredict reloads the timer.
        runCycle(mk(1, 16, 17, 4, 1, 0, 0), "r036.prod");
        runCycle(mk(1, 4, 18, 0, 0, 0, 1), "r036.both");
        checkOutput("r036.st", 32'(hzBus.ctrl_state), 32'd2);
        runCycle(mk(1, 4, 18, 0, 0, 0, 0), "r036.f1");
        runCycle(mk(1, 4, 18, 0, 0, 0, 1), "r024.re");
        repeat (3) runCycle(idle, "r024.tail");

        // Counter saturation near the top.
        force dut.r_stall_cnt = 16'hFFFE;
        #1;
        release dut.r_stall_cnt;
        mStallCnt = 16'hFFFE;
        runCycle(mk(1, 19, 19, 5, 1, 1, 0), "r037.prod");
        rd = mk(1, 5, 22, 0, 0, 0, 0);
        repeat (4) runCycle(rd, "r037.cons");
        checkOutput("r037.sat", 32'(hzBus.stall_cnt), 32'hFFFF);
        runCycle(idle, "r037.idle");

        // Reset in the first flush cycle.
        runCycle(mk(0, 0, 0, 0, 0, 0, 1), "r038.mis");
        checkOutput("r038.pre", 32'(hzBus.flush_if), 32'd1);
        rst = 1'b1;
        applyStimulus(idle);
        #1;
        checkAllZero("r038.rst");
        resetModel();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (4) runCycle(idle, "r038.after");

        for (int n = 0; n < 400; n++) begin
            runCycle(mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 15) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/decode_hazard_ctrl.md
DECODE_HAZARD_CTRL -- requirements
Module: decode_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: cycles the FLUSH state holds flush_if/flush_id asserted; legal range 1..7.
REQ-002 Parameter TRACK_DEPTH, default 3: in-flight destination entries tracked (EX, MEM, WB).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_src1, id_src2  in  5 each  register read indices of the ID instruction.
REQ-007 id_dest  in  5  destination register index of the ID instruction.
REQ-008 id_writes  in  1  ID instruction writes id_dest.
REQ-009 id_is_load  in  1  ID instruction is a memory load.
REQ-010 ex_mispredict  in  1  EX resolved a branch against BRANCH_PRED; one-cycle pulse.
REQ-011 stall_if  out  1  hold PC and the IF/ID register.
REQ-012 stall_id  out  1  hold the ID/EX inputs; equal to stall_if.
REQ-013 bubble_ex  out  1  load a NOP into ID/EX (CTRL_ID cleared).
REQ-014 flush_if, flush_id  out  1 each  squash IF/ID and ID/EX contents.
REQ-015 ctrl_state  out  2  current state encoding: RUN=0, STALL=1, FLUSH=2.
REQ-016 stall_cnt  out  16  count of cycles spent in STALL, saturating.

Function
REQ-017 Tracker: TRACK_DEPTH-entry shift register of {valid, dest, is_load}; entry 0 = EX, advances every cycle unconditionally.
REQ-018 Entry 0 loads {id_valid&id_writes, id_dest, id_is_load} when state is RUN and no hazard; otherwise it loads valid=0.
REQ-019 Hazard (combinational) = id_valid and any valid entry whose dest equals id_src1 or id_src2; all 32 indices are checked, index 0 included.
REQ-020 RUN: hazard -> STALL next cycle; ex_mispredict -> FLUSH next cycle; ex_mispredict has priority over hazard.
REQ-021 STALL: stays while hazard holds; leaves to RUN the first cycle hazard is false; ex_mispredict -> FLUSH with priority.
REQ-022 stall_if = stall_id = bubble_ex = hazard while state is RUN or STALL; all three 0 in FLUSH.
REQ-023 FLUSH: flush_if = flush_id = 1 for exactly FLUSH_CYCLES cycles (3-bit down-counter), then RUN; tracker entry 0 valid forced 0 on every FLUSH cycle.
REQ-024 ex_mispredict arriving during FLUSH reloads the counter to FLUSH_CYCLES.
REQ-025 stall_cnt increments by 1 in every cycle with state STALL; holds at 16'hFFFF.
REQ-026 Hazard latency: stall_if asserts in the same cycle the conflicting instruction is in ID; release in the cycle the last matching entry leaves WB.

Reset
REQ-027 rst asserted: state=RUN, tracker valid bits=0, flush counter=0, stall_cnt=0; outputs stall_if/stall_id/bubble_ex/flush_if/flush_id=0.
REQ-028 rst mid-STALL or mid-FLUSH aborts immediately; no flush pulse completes after reset release.

Configuration
REQ-029 DECODE_HAZARD_FORWARD_EN defined: hazard compares only tracker entry 0 and only when its is_load=1 (load-use); other dependencies are left to forwarding.
REQ-030 DECODE_HAZARD_FORWARD_EN undefined: hazard compares all TRACK_DEPTH entries regardless of is_load (REQ-019).

Structure
REQ-031 Shared package pipe_pkg: state enum (RUN/STALL/FLUSH), REG_IDX_W=5, tracker entry struct.
REQ-032 One sub-module hazard_tracker: shift register plus comparators, emitting hazard; FSM, flush counter, stall_cnt live in the top.

Verification
REQ-033 EX entry r3 (non-load), ID src1=3, forward undefined -> stall_if=1 for 3 cycles, bubble_ex=1, stall_cnt=3, then RUN.
REQ-034 Same stimulus with DECODE_HAZARD_FORWARD_EN -> no stall; EX load to r7, ID src2=7 -> exactly 1 stall cycle.
REQ-035 ex_mispredict pulse in RUN -> flush_if=flush_id=1 for 2 cycles, ctrl_state=2 then 0, tracker entry 0 invalid.
REQ-036 Hazard and ex_mispredict in same cycle -> FLUSH next, stall outputs 0 during FLUSH.
REQ-037 stall_cnt preset near 16'hFFFE, 3 stall cycles -> holds 16'hFFFF.
REQ-038 rst asserted during FLUSH cycle 1 -> all outputs 0 asynchronously, RUN after release, no residual flush.
